snake_body_engine: RTL and testbench
====================================

Name: snake_body_engine

Overview:
- Parametrised snake body store and move sequencer; successor to the fixed-length snake datapath.
- Holds up to MAX_LEN segment grid coordinates in a circular buffer and executes init/step commands.
- Checks wall and self collision, supports growth, and streams erase (tail) and draw (head) pixels to the VGA plotter.
- Sits between the game-control FSM (commands, direction) and the VGA adapter (x, y, colour, plot_en).

Parameters:
- MAX_LEN, 64, buffer depth (maximum snake length), power of 2.
- INIT_LEN, 4, length after init, 1..MAX_LEN.
- GRID_W, 80, grid columns; legal gx is 0..GRID_W-1.
- GRID_H, 60, grid rows; legal gy is 0..GRID_H-1.
- SEG, 2, segment edge in pixels; pixel = grid*SEG + offset.
- INIT_X, 30, initial head column.
- INIT_Y, 30, initial head row; INIT_Y+INIT_LEN-1 must be less than GRID_H.
- PX_W, 8, pixel x width.
- PY_W, 7, pixel y width.

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, asynchronous, active-low
- init  in  1  pulse: load initial snake and draw it
- step  in  1  pulse: advance one cell
- grow  in  1  sampled with step: do not pop tail
- dir  in  2  sampled with step: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when init or step completes
- dead  out  1  sticky collision flag
- length  out  clog2(MAX_LEN)+1  current segment count
- head_x  out  clog2(GRID_W)  current head column
- head_y  out  clog2(GRID_H)  current head row
- plot_en  out  1  pixel valid
- x  out  PX_W  pixel x
- y  out  PY_W  pixel y
- colour  out  1  1 = draw, 0 = erase

Behaviour:
- Reset values: all outputs 0; head pointer 0, tail pointer 0, last_dir 00; FSM in IDLE.
- Buffer: head_ptr indexes the head entry; tail = head_ptr - length + 1 mod MAX_LEN. Pointers wrap modulo MAX_LEN.
- States: IDLE, FILL, IDRAW, CALC, SCAN, ERASE, DRAW, DONE.
- init:
  - Accepted in any state and aborts any operation in progress; takes priority over step.
  - Clears dead, sets last_dir to 00 (up).
  - FILL: INIT_LEN cycles, writes segment i = (INIT_X, INIT_Y+i), with i = 0 as the head.
  - IDRAW: draws every segment from head to tail, SEG*SEG cycles each, colour 1.
  - DONE: one cycle, then IDLE.
- step:
  - Accepted only in IDLE with dead=0 and length not 0; otherwise ignored with no done pulse.
  - step while busy is dropped, not queued.
  - dir and grow are latched on acceptance.
- Reversal: a dir opposite last_dir is replaced by last_dir.
- CALC (1 cycle): compute the new head.
  - Wall collision: x-1 at 0, x+1 at GRID_W-1, y-1 at 0, or y+1 at GRID_H-1. No wrap-around.
  - On wall collision: dead=1, go to DONE, nothing is plotted and no state other than dead changes.
- Effective grow: eg = grow AND length < MAX_LEN. At full length, grow acts as a normal move.
- SCAN: one entry per cycle from the head toward the tail.
  - Compares eg ? length : length-1 entries; the vacating tail is excluded when not growing.
  - On a match: dead=1, go to DONE, buffer unchanged, nothing plotted.
- ERASE (only if eg=0): SEG*SEG cycles of tail pixels with colour 0, then pop the tail.
- DRAW:
  - Push the new head (head_ptr+1) and update last_dir.
  - If eg=1, length increments.
  - SEG*SEG cycles of head pixels with colour 1.
- Pixel order: offset k = 0..SEG*SEG-1; dx = k / SEG, dy = k mod SEG; x = gx*SEG + dx, y = gy*SEG + dy.
- plot_en is high exactly in IDRAW, ERASE and DRAW cycles; x, y and colour are 0 otherwise.
- done: 1 in DONE only.
- Step latency from the accepting edge: done high in cycle 1 + 1 + Nscan + (eg ? 0 : SEG*SEG) + SEG*SEG.
- head_x and head_y update when the head is pushed; length updates in the same cycle.
- Reset mid-operation returns to the reset state immediately; a partial plot is abandoned.

Test Plan:
- Reset then init (defaults) -> 4 FILL cycles, 16 draw pixels, first (60,60) colour 1; done; length=4, head=(30,30), dead=0.
- step dir=11 grow=0 after init -> done 13 cycles after the accepting edge; erase pixels (60,66),(60,67),(61,66),(61,67) colour 0; draw (62,60)..(63,61); head=(31,30); length=4.
- step dir=01 (reverse of up) right after init -> treated as up; head=(30,29).
- step grow=1 -> no erase cycles; length=5; done 1+1+4+4 = 10 cycles after acceptance. Repeat to length 64, then grow=1 -> length stays 64 and the tail is erased.
- Head at y=0, step dir=00 -> dead=1 and done with no plot_en. Following step -> ignored. init -> dead=0.
- Snake length 5, steps right, down, left, up -> self-collision: dead=1. Same loop at length 4 -> legal (tail excluded), dead=0. step while busy -> dropped.

Source files
------------

// File: rtl/snake_body_engine.sv
// Snake body store and move sequencer.
// Segment coordinates live in a circular buffer indexed from the head
// pointer; the tail is derived as head_ptr - length + 1. Commands arrive
// as single-cycle init/step pulses, and pixels are streamed out to the
// VGA plotter as erase (tail) and draw (head) bursts of SEG*SEG pixels.
//
// Handshake: init and step are single-cycle request pulses with no ready.
// init is always taken and aborts whatever is in flight. step is taken
// only in IDLE with dead=0 and a non-empty body, and is silently dropped
// otherwise. busy is high in every state except IDLE, and done pulses
// for exactly one cycle when an accepted command finishes.
module snake_body_engine #(
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 4,
    parameter int GRID_W   = 80,
    parameter int GRID_H   = 60,
    parameter int SEG      = 2,
    parameter int INIT_X   = 30,
    parameter int INIT_Y   = 30,
    parameter int PX_W     = 8,
    parameter int PY_W     = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init,
    input  logic                          step,
    input  logic                          grow,
    input  logic [1:0]                    dir,
    output logic                          busy,
    output logic                          done,
    output logic                          dead,
    output logic [$clog2(MAX_LEN):0]      length,
    output logic [$clog2(GRID_W)-1:0]     head_x,
    output logic [$clog2(GRID_H)-1:0]     head_y,
    output logic                          plot_en,
    output logic [PX_W-1:0]               x,
    output logic [PY_W-1:0]               y,
    output logic                          colour
);

    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int LEN_W = PTR_W + 1;
    localparam int GX_W  = $clog2(GRID_W);
    localparam int GY_W  = $clog2(GRID_H);
    localparam int K_W   = $clog2(SEG * SEG + 1);

    localparam logic [K_W-1:0]   PIX_LAST   = K_W'(SEG * SEG - 1);
    localparam logic [K_W-1:0]   SEG_K      = K_W'(SEG);
    localparam logic [LEN_W-1:0] ONE_L      = LEN_W'(1);
    localparam logic [LEN_W-1:0] INIT_LEN_L = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L  = LEN_W'(MAX_LEN);
    localparam logic [GX_W-1:0]  GX_MAX     = GX_W'(GRID_W - 1);
    localparam logic [GY_W-1:0]  GY_MAX     = GY_W'(GRID_H - 1);
    localparam logic [GX_W-1:0]  INIT_X_L   = GX_W'(INIT_X);
    localparam logic [GY_W-1:0]  INIT_Y_L   = GY_W'(INIT_Y);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_IDRAW, S_CALC, S_SCAN, S_ERASE, S_DRAW, S_DONE
    } state_t;

    typedef struct packed {
        logic [GX_W-1:0] gx;
        logic [GY_W-1:0] gy;
    } cell_t;

    state_t            state;
    state_t            state_next;
    cell_t             mem [MAX_LEN];
    logic [PTR_W-1:0]  head_ptr;
    logic [1:0]        last_dir;
    logic [1:0]        cur_dir;
    logic              eg;
    logic [LEN_W-1:0]  fill_idx;
    logic [LEN_W-1:0]  seg_idx;
    logic [LEN_W-1:0]  scan_idx;
    logic [K_W-1:0]    pix_k;
    cell_t             new_cell;

    logic              accept;
    logic              pix_last;
    logic [LEN_W-1:0]  scan_n;
    logic [PTR_W-1:0]  rd_ptr;
    cell_t             rd_cell;
    cell_t             nxt_cell;
    logic              wall;
    logic              hit;
    logic              we;
    logic [PTR_W-1:0]  waddr;
    cell_t             wdata;
    cell_t             pix_cell;
    logic [K_W-1:0]    dx;
    logic [K_W-1:0]    dy;

    assign accept   = (state == S_IDLE) && step && !dead && (length != '0);
    assign pix_last = (pix_k == PIX_LAST);
    // Without growth the tail cell vacates this move, so it is not a hazard.
    assign scan_n   = eg ? length : length - ONE_L;
    assign rd_cell  = mem[rd_ptr];
    assign hit      = (state == S_SCAN) && (rd_cell == new_cell);

    // Read-pointer selection: body walk for IDRAW/SCAN, tail for ERASE.
    always_comb begin
        rd_ptr = head_ptr;
        case (state)
            S_IDRAW: rd_ptr = head_ptr - PTR_W'(seg_idx);
            S_SCAN:  rd_ptr = head_ptr - PTR_W'(scan_idx);
            S_ERASE: rd_ptr = head_ptr - PTR_W'(length) + PTR_W'(1);
            default: rd_ptr = head_ptr;
        endcase
    end

    // Candidate new head and wall test; there is no wrap-around.
    always_comb begin
        nxt_cell.gx = head_x;
        nxt_cell.gy = head_y;
        wall        = 1'b0;
        case (cur_dir)
            2'b00: if (head_y == '0)    wall = 1'b1; else nxt_cell.gy = head_y - GY_W'(1);
            2'b01: if (head_y == GY_MAX) wall = 1'b1; else nxt_cell.gy = head_y + GY_W'(1);
            2'b10: if (head_x == '0)    wall = 1'b1; else nxt_cell.gx = head_x - GX_W'(1);
            default: if (head_x == GX_MAX) wall = 1'b1; else nxt_cell.gx = head_x + GX_W'(1);
        endcase
    end

    // Buffer write port: initial body during FILL, new head on the first DRAW cycle.
    always_comb begin
        we    = 1'b0;
        waddr = head_ptr;
        wdata = '0;
        if (!init) begin
            if (state == S_FILL) begin
                we       = 1'b1;
                waddr    = head_ptr - PTR_W'(fill_idx);
                wdata.gx = INIT_X_L;
                wdata.gy = INIT_Y_L + GY_W'(fill_idx);
            end else if (state == S_DRAW && pix_k == '0) begin
                we    = 1'b1;
                waddr = head_ptr + PTR_W'(1);
                wdata = new_cell;
            end
        end
    end

    // Segment storage; contents outside the live body are never read.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic; init overrides everything.
    always_comb begin
        state_next = state;
        if (init) begin
            state_next = S_FILL;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_next = S_CALC;
                S_FILL:  if (fill_idx == INIT_LEN_L - ONE_L) state_next = S_IDRAW;
                S_IDRAW: if (pix_last && seg_idx == INIT_LEN_L - ONE_L) state_next = S_DONE;
                S_CALC: begin
                    if (wall)               state_next = S_DONE;
                    else if (scan_n == '0)  state_next = S_ERASE;
                    else                    state_next = S_SCAN;
                end
                S_SCAN: begin
                    if (hit)                                state_next = S_DONE;
                    else if (scan_idx == scan_n - ONE_L)    state_next = eg ? S_DRAW : S_ERASE;
                end
                S_ERASE: if (pix_last) state_next = S_DRAW;
                S_DRAW:  if (pix_last) state_next = S_DONE;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Body bookkeeping: pointers, length, head, collision flag and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            length   <= '0;
            dead     <= 1'b0;
            last_dir <= 2'b00;
            cur_dir  <= 2'b00;
            eg       <= 1'b0;
            head_x   <= '0;
            head_y   <= '0;
            fill_idx <= '0;
            seg_idx  <= '0;
            scan_idx <= '0;
            pix_k    <= '0;
            new_cell <= '0;
        end else if (init) begin
            head_ptr <= '0;
            length   <= '0;
            dead     <= 1'b0;
            last_dir <= 2'b00;
            fill_idx <= '0;
            seg_idx  <= '0;
            scan_idx <= '0;
            pix_k    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // A reversal would run into the neck; keep going the old way.
                        cur_dir  <= (dir == {last_dir[1], ~last_dir[0]}) ? last_dir : dir;
                        eg       <= grow && (length < MAX_LEN_L);
                        scan_idx <= '0;
                    end
                end
                S_FILL: begin
                    length   <= fill_idx + ONE_L;
                    fill_idx <= fill_idx + ONE_L;
                    if (fill_idx == '0) begin
                        head_x <= INIT_X_L;
                        head_y <= INIT_Y_L;
                    end
                end
                S_IDRAW: begin
                    pix_k <= pix_last ? '0 : pix_k + K_W'(1);
                    if (pix_last) seg_idx <= seg_idx + ONE_L;
                end
                S_CALC: begin
                    if (wall) dead <= 1'b1;
                    else      new_cell <= nxt_cell;
                end
                S_SCAN: begin
                    if (hit) dead <= 1'b1;
                    else     scan_idx <= scan_idx + ONE_L;
                end
                S_ERASE: begin
                    pix_k <= pix_last ? '0 : pix_k + K_W'(1);
                end
                S_DRAW: begin
                    pix_k <= pix_last ? '0 : pix_k + K_W'(1);
                    if (pix_k == '0) begin
                        // Pushing the head with unchanged length pops the tail implicitly.
                        head_ptr <= head_ptr + PTR_W'(1);
                        head_x   <= new_cell.gx;
                        head_y   <= new_cell.gy;
                        last_dir <= cur_dir;
                        if (eg) length <= length + ONE_L;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel stream and status outputs.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        plot_en  = (state == S_IDRAW) || (state == S_ERASE) || (state == S_DRAW);
        colour   = (state == S_IDRAW) || (state == S_DRAW);
        pix_cell = (state == S_DRAW) ? new_cell : rd_cell;
        dx       = pix_k / SEG_K;
        dy       = pix_k % SEG_K;
        x        = '0;
        y        = '0;
        if (plot_en) begin
            x = PX_W'(pix_cell.gx) * PX_W'(SEG) + PX_W'(dx);
            y = PY_W'(pix_cell.gy) * PY_W'(SEG) + PY_W'(dy);
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed scenarios plus a random command
// stream, checked against a queue-based model of the snake body.
module tb_snake_body_engine;

    localparam int MAX_LEN  = 64;
    localparam int INIT_LEN = 4;
    localparam int GRID_W   = 80;
    localparam int GRID_H   = 60;
    localparam int SEG      = 2;
    localparam int INIT_X   = 30;
    localparam int INIT_Y   = 30;
    localparam int PX_W     = 8;
    localparam int PY_W     = 7;
    localparam int PIX_W    = PX_W + PY_W + 1;

    logic             clk;
    logic             rst;
    logic             init;
    logic             step;
    logic             grow;
    logic [1:0]       dir;
    logic             busy;
    logic             done;
    logic             dead;
    logic [6:0]       length;
    logic [6:0]       head_x;
    logic [5:0]       head_y;
    logic             plot_en;
    logic [PX_W-1:0]  x;
    logic [PY_W-1:0]  y;
    logic             colour;

    int checks   = 0;
    int failures = 0;
    int last_lat = 0;

    // model: body cells, head at index 0
    int               m_x[$];
    int               m_y[$];
    bit               m_dead;
    logic [1:0]       m_last_dir;
    logic [PIX_W-1:0] exp_q[$];
    logic [PIX_W-1:0] op_pix[$];

    snake_body_engine dut (
        .clk(clk), .rst(rst), .init(init), .step(step), .grow(grow), .dir(dir),
        .busy(busy), .done(done), .dead(dead), .length(length),
        .head_x(head_x), .head_y(head_y), .plot_en(plot_en),
        .x(x), .y(y), .colour(colour)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // per-cycle compare of the pixel stream against the expected queue
    task automatic cycle_compare();
        logic [PIX_W-1:0] got;
        logic [PIX_W-1:0] e;
        got = {x, y, colour};
        checks++;
        if (plot_en === 1'b1) begin
            op_pix.push_back(got);
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pixel_extra got x=%0d y=%0d colour=%0d required no plot", x, y, colour);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL pixel got x=%0d y=%0d colour=%0d required x=%0d y=%0d colour=%0d",
                             x, y, colour, e[PIX_W-1 -: PX_W], e[PY_W:1], e[0]);
                end
            end
        end else if (plot_en !== 1'b0 || got !== '0) begin
            failures++;
            $display("FAIL pixel_idle got plot_en=%0d x=%0d y=%0d colour=%0d required all 0",
                     plot_en, x, y, colour);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_compare();
    endtask

    function automatic logic [PIX_W-1:0] pix_at(input int i);
        if (op_pix.size() > i) return op_pix[i];
        return '1;
    endfunction

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;
            2'b01:   return 2'b00;
            2'b10:   return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic push_cell(input int gx, input int gy, input bit c);
        for (int k = 0; k < SEG * SEG; k++)
            exp_q.push_back({PX_W'(gx * SEG + k / SEG), PY_W'(gy * SEG + k % SEG), c});
    endtask

    task automatic check_state(input string name);
        check({name, "_length"}, length, m_x.size());
        check({name, "_head_x"}, head_x, (m_x.size() > 0) ? m_x[0] : 0);
        check({name, "_head_y"}, head_y, (m_y.size() > 0) ? m_y[0] : 0);
        check({name, "_dead"}, dead, m_dead);
    endtask

    task automatic idle_check(input string name);
        bit ok;
        ok = 1'b1;
        repeat (6) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        check(name, ok, 1);
    endtask

    task automatic wait_done(input int req_lat, input string name, input int drop_at);
        int n;
        bit busy_ok;
        n = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 400) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n == drop_at) begin
                step = 1'b1;
                dir  = 2'($urandom_range(0, 3));
            end else begin
                step = 1'b0;
            end
            tick();
            n++;
        end
        step = 1'b0;
        last_lat = n;
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=no done required=done after %0d cycles", name, req_lat);
        end else begin
            check(name, n, req_lat);
        end
        check({name, "_busy"}, busy_ok, 1);
        check({name, "_pixels_left"}, exp_q.size(), 0);
        exp_q.delete();
        tick();
        check({name, "_done_pulse"}, {done, busy}, 0);
    endtask

    task automatic do_init();
        m_x.delete();
        m_y.delete();
        exp_q.delete();
        op_pix.delete();
        for (int i = 0; i < INIT_LEN; i++) begin
            m_x.push_back(INIT_X);
            m_y.push_back(INIT_Y + i);
            push_cell(INIT_X, INIT_Y + i, 1'b1);
        end
        m_dead     = 1'b0;
        m_last_dir = 2'b00;
        init = 1'b1;
        tick();
        init = 1'b0;
        wait_done(INIT_LEN + INIT_LEN * SEG * SEG + 1, "init_latency", 0);
        check_state("init");
    endtask

    task automatic do_step(input logic [1:0] d, input bit g, input int drop_at, input bit no_wait);
        int nx, ny, n, j, lat, len;
        logic [1:0] e;
        bit eg, wall, hit;
        op_pix.delete();
        dir  = d;
        grow = g;
        len  = m_x.size();
        if (m_dead || len == 0) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            grow = 1'b0;
            idle_check("step_ignored");
            check_state("ignored");
            return;
        end
        e    = (d == opposite(m_last_dir)) ? m_last_dir : d;
        nx   = m_x[0];
        ny   = m_y[0];
        wall = 1'b0;
        lat  = 0;
        case (e)
            2'b00:   if (ny == 0)          wall = 1'b1; else ny = ny - 1;
            2'b01:   if (ny == GRID_H - 1) wall = 1'b1; else ny = ny + 1;
            2'b10:   if (nx == 0)          wall = 1'b1; else nx = nx - 1;
            default: if (nx == GRID_W - 1) wall = 1'b1; else nx = nx + 1;
        endcase
        if (wall) begin
            m_dead = 1'b1;
            lat    = 2;
        end else begin
            eg  = g && (len < MAX_LEN);
            n   = eg ? len : len - 1;
            hit = 1'b0;
            j   = 0;
            for (int i = 0; i < n; i++)
                if (!hit && m_x[i] == nx && m_y[i] == ny) begin
                    hit = 1'b1;
                    j   = i;
                end
            if (hit) begin
                m_dead = 1'b1;
                lat    = 3 + j;
            end else begin
                if (!eg) begin
                    push_cell(m_x[len - 1], m_y[len - 1], 1'b0);
                    void'(m_x.pop_back());
                    void'(m_y.pop_back());
                end
                push_cell(nx, ny, 1'b1);
                m_x.push_front(nx);
                m_y.push_front(ny);
                m_last_dir = e;
                lat = 2 + n + (eg ? 0 : SEG * SEG) + SEG * SEG;
            end
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        grow = 1'b0;
        if (no_wait) return;
        wait_done(lat, "step_latency", drop_at);
        check_state("step");
    endtask

    // stimulus and report
    initial begin
        rst = 1'b0; init = 1'b0; step = 1'b0; grow = 1'b0; dir = 2'b00;
        m_dead = 1'b0; m_last_dir = 2'b00;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dead", dead, 0);
        check("reset_length", length, 0);
        check("reset_head", {head_x, head_y}, 0);
        check("reset_pixel", {plot_en, x, y, colour}, 0);

        // empty body: step must be ignored
        do_step(2'b11, 1'b0, 0, 1'b0);

        // init, first pixel and count
        do_init();
        check("init_latency_lit", last_lat, 21);
        check("init_first_pixel", pix_at(0), {8'd60, 7'd60, 1'b1});
        check("init_pixel_count", op_pix.size(), 16);
        check("init_length_lit", length, 4);

        // plain move right
        do_step(2'b11, 1'b0, 0, 1'b0);
        check("right_latency_lit", last_lat, 13);
        check("right_erase0", pix_at(0), {8'd60, 7'd66, 1'b0});
        check("right_erase3", pix_at(3), {8'd61, 7'd67, 1'b0});
        check("right_draw0", pix_at(4), {8'd62, 7'd60, 1'b1});
        check("right_draw3", pix_at(7), {8'd63, 7'd61, 1'b1});
        check("right_head_lit", {head_x, head_y}, {7'd31, 6'd30});

        // reversal is ignored
        do_init();
        do_step(2'b01, 1'b0, 0, 1'b0);
        check("reverse_head_lit", {head_x, head_y}, {7'd30, 6'd29});

        // growth to full length, pointer wrap, grow at full length
        do_init();
        do_step(2'b11, 1'b1, 0, 1'b0);
        check("grow_latency_lit", last_lat, 10);
        check("grow_length_lit", length, 5);
        for (int i = 0; i < 48; i++) do_step(2'b11, 1'b1, 0, 1'b0);
        do_step(2'b01, 1'b1, 0, 1'b0);
        for (int i = 0; i < 10; i++) do_step(2'b10, 1'b1, 0, 1'b0);
        check("full_length_lit", length, 64);
        do_step(2'b10, 1'b1, 0, 1'b0);
        check("full_grow_latency_lit", last_lat, 73);
        check("full_grow_length_lit", length, 64);
        check("full_grow_erase0", pix_at(0), {8'd60, 7'd66, 1'b0});

        // wall collision at the top row
        do_init();
        for (int i = 0; i < 30; i++) do_step(2'b00, 1'b0, 0, 1'b0);
        check("top_row_lit", head_y, 0);
        do_step(2'b00, 1'b0, 0, 1'b0);
        check("wall_dead_lit", dead, 1);
        check("wall_latency_lit", last_lat, 2);
        check("wall_no_plot", op_pix.size(), 0);
        do_step(2'b11, 1'b0, 0, 1'b0);
        do_init();
        check("init_clears_dead", dead, 0);

        // self collision at length 5
        do_init();
        do_step(2'b11, 1'b1, 0, 1'b0);
        do_step(2'b01, 1'b0, 0, 1'b0);
        do_step(2'b10, 1'b0, 0, 1'b0);
        check("self_dead_lit", dead, 1);
        check("self_latency_lit", last_lat, 6);
        do_step(2'b00, 1'b0, 0, 1'b0);

        // the same loop at length 4 chases its own tail legally
        do_init();
        do_step(2'b11, 1'b0, 0, 1'b0);
        do_step(2'b01, 1'b0, 0, 1'b0);
        do_step(2'b10, 1'b0, 0, 1'b0);
        do_step(2'b00, 1'b0, 0, 1'b0);
        check("loop4_dead_lit", dead, 0);
        check("loop4_head_lit", {head_x, head_y}, {7'd30, 6'd30});

        // step while busy is dropped
        do_init();
        do_step(2'b11, 1'b0, 4, 1'b0);
        check("drop_head_lit", {head_x, head_y}, {7'd31, 6'd30});
        idle_check("drop_no_second_op");

        // init aborts a step in flight
        do_init();
        do_step(2'b11, 1'b0, 0, 1'b1);
        repeat ($urandom_range(2, 10)) tick();
        do_init();
        do_step(2'b10, 1'b0, 0, 1'b0);

        // asynchronous reset mid-operation
        do_step(2'b10, 1'b0, 0, 1'b1);
        repeat (5) tick();
        #2 rst = 1'b0;
        #1;
        check("async_reset_outputs", {busy, done, dead, length, head_x, head_y, plot_en, x, y, colour}, 0);
        exp_q.delete();
        m_x.delete();
        m_y.delete();
        m_dead = 1'b0;
        m_last_dir = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        check_state("after_reset");
        do_step(2'b00, 1'b0, 0, 1'b0);

        // random command stream
        for (int i = 0; i < 200; i++) begin
            if (m_dead || m_x.size() == 0 || $urandom_range(0, 19) == 0)
                do_init();
            else
                do_step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 8)) : 0, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
